// File: rtl/buffer_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : buffer_mem_responder_if
// Description : Bundles the core-side SRAM bus (active-low cenb/wenb, address,
//               write/read data) and the byte-serial host LOAD/DUMP port of one
//               buffer responder. Signal suffixes are relative to the responder.
//               Port summary:
//                 core  : mem_cenb_i, mem_wenb_i, mem_addr_i, mem_data_i -> mem_data_o
//                 cmd   : start_i, dir_i, base_addr_i, len_i
//                 load  : ld_valid_i, ld_byte_i -> ld_ready_o
//                 dump  : dp_valid_o, dp_byte_o <- dp_ready_i
//                 status: busy_o, done_o
//               master = core/host side, slave = responder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface buffer_mem_responder_if #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 9
);
    // Core SRAM-style bus
    logic                     mem_cenb_i;
    logic                     mem_wenb_i;
    logic [ADDR_W-1:0]        mem_addr_i;
    logic [WIDTH*LANES-1:0]   mem_data_i;
    logic [WIDTH*LANES-1:0]   mem_data_o;
    // Host command
    logic                     start_i;
    logic                     dir_i;
    logic [ADDR_W-1:0]        base_addr_i;
    logic [ADDR_W:0]          len_i;
    // Host LOAD stream
    logic                     ld_valid_i;
    logic [WIDTH-1:0]         ld_byte_i;
    logic                     ld_ready_o;
    // Host DUMP stream
    logic                     dp_valid_o;
    logic [WIDTH-1:0]         dp_byte_o;
    logic                     dp_ready_i;
    // Status
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output mem_cenb_i, mem_wenb_i, mem_addr_i, mem_data_i,
        input  mem_data_o,
        output start_i, dir_i, base_addr_i, len_i,
        output ld_valid_i, ld_byte_i,
        input  ld_ready_o,
        input  dp_valid_o, dp_byte_o,
        output dp_ready_i,
        input  busy_o, done_o
    );

    modport slave (
        input  mem_cenb_i, mem_wenb_i, mem_addr_i, mem_data_i,
        output mem_data_o,
        input  start_i, dir_i, base_addr_i, len_i,
        input  ld_valid_i, ld_byte_i,
        output ld_ready_o,
        output dp_valid_o, dp_byte_o,
        input  dp_ready_i,
        output busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/buffer_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : buffer_mem_responder
// Description : Responder end of the active-low SRAM-style buffer bus used by
//               the matrix-mult core. Holds DEPTH words of LANES*WIDTH bits,
//               serves core reads (1-cycle latency, registered) and writes
//               while idle, and offers a byte-serial host port:
//               LOAD assembles LANES bytes (lane 0 first) into a word and
//               writes it; DUMP reads a word and streams it out lane 0 first.
//               Ports: clk_i, rst_i (sync, active high), bus (slave modport).
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_mem_responder #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    buffer_mem_responder_if.slave  bus
);

    localparam int c_WORD_W = WIDTH * LANES;
    localparam int c_LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_DUMP_RD = 2'd2,
        S_DUMP_TX = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]        words_left_q, words_left_d;
    logic [c_LANE_W-1:0]    lane_q, lane_d;
    logic [c_WORD_W-1:0]    asm_q, asm_d;       // LOAD word under assembly
    logic [c_WORD_W-1:0]    shift_q, shift_d;   // DUMP word, lane 0 in low bits
    logic [c_WORD_W-1:0]    rdata_q, rdata_d;   // core read data register
    logic                   done_q, done_d;

    // Storage array; intentionally not reset
    logic [c_WORD_W-1:0]    mem_q [DEPTH];

    logic                   w_mem_we;
    logic [ADDR_W-1:0]      w_mem_waddr;
    logic [c_WORD_W-1:0]    w_mem_wdata;
    logic [c_WORD_W-1:0]    w_asm_word;
    logic [ADDR_W-1:0]      w_addr_inc;
    logic                   w_last_lane;
    logic                   w_last_word;

    // Address advance wraps at DEPTH-1 so non power-of-two depths also wrap
    assign w_addr_inc  = (cur_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : cur_addr_q + 1'b1;
    assign w_last_lane = (lane_q == c_LANE_W'(LANES - 1));
    assign w_last_word = (words_left_q == (ADDR_W + 1)'(1));

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        words_left_d = words_left_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        shift_d      = shift_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_waddr  = cur_addr_q;
        w_mem_wdata  = asm_q;

        // Current partial word with the incoming host byte merged into its lane
        w_asm_word = asm_q;
        w_asm_word[lane_q*WIDTH +: WIDTH] = bus.ld_byte_i;

        case (state_q)
            S_IDLE: begin
                if (!bus.mem_cenb_i) begin
                    if (bus.mem_wenb_i) begin
                        rdata_d = mem_q[bus.mem_addr_i];
                    end else begin
                        w_mem_we    = 1'b1;
                        w_mem_waddr = bus.mem_addr_i;
                        w_mem_wdata = bus.mem_data_i;
                    end
                end
                if (bus.start_i) begin
                    cur_addr_d   = bus.base_addr_i;
                    words_left_d = bus.len_i;
                    lane_d       = '0;
                    asm_d        = '0;
                    if (bus.len_i == '0) begin
                        // Empty transfer: complete immediately without leaving IDLE
                        done_d = 1'b1;
                    end else if (bus.dir_i) begin
                        state_d = S_DUMP_RD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (bus.ld_valid_i) begin
                    asm_d  = w_asm_word;
                    lane_d = lane_q + 1'b1;
                    if (w_last_lane) begin
                        // Final byte goes straight into the array on this edge
                        w_mem_we     = 1'b1;
                        w_mem_waddr  = cur_addr_q;
                        w_mem_wdata  = w_asm_word;
                        lane_d       = '0;
                        cur_addr_d   = w_addr_inc;
                        words_left_d = words_left_q - 1'b1;
                        if (w_last_word) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            S_DUMP_RD: begin
                shift_d = mem_q[cur_addr_q];
                lane_d  = '0;
                state_d = S_DUMP_TX;
            end

            S_DUMP_TX: begin
                if (bus.dp_ready_i) begin
                    shift_d = shift_q >> WIDTH;
                    lane_d  = lane_q + 1'b1;
                    if (w_last_lane) begin
                        lane_d       = '0;
                        cur_addr_d   = w_addr_inc;
                        words_left_d = words_left_q - 1'b1;
                        if (w_last_word) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DUMP_RD;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            words_left_q <= '0;
            lane_q       <= '0;
            asm_q        <= '0;
            shift_q      <= '0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            words_left_q <= words_left_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            shift_q      <= shift_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
        end
    end

    // A write coinciding with reset is dropped so an aborted LOAD never
    // commits the word that was in flight.
    always_ff @(posedge clk_i) begin
        if (w_mem_we && !rst_i) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign bus.mem_data_o = rdata_q;
    assign bus.dp_byte_o  = shift_q[WIDTH-1:0];
    assign bus.ld_ready_o = (state_q == S_LOAD);
    assign bus.dp_valid_o = (state_q == S_DUMP_TX);
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_buffer_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_mem_responder
// Description : Self-checking bench for buffer_mem_responder. A word array in
//               the bench holds the expected buffer contents; LOAD words are
//               built from the byte list and DUMP byte streams are expected
//               from the stored words, lane 0 first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_mem_responder;

    localparam int WIDTH  = 8;
    localparam int LANES  = 4;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buffer_mem_responder_if #(.WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    buffer_mem_responder #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          ref_ok  [DEPTH];
    logic [7:0]  ld_bytes [$];

    typedef struct {
        logic        cenb;
        logic        wenb;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.mem_cenb_i  = 1'b1;
        bus.mem_wenb_i  = 1'b1;
        bus.mem_addr_i  = '0;
        bus.mem_data_i  = '0;
        bus.start_i     = 1'b0;
        bus.dir_i       = 1'b0;
        bus.base_addr_i = '0;
        bus.len_i       = '0;
        bus.ld_valid_i  = 1'b0;
        bus.ld_byte_i   = '0;
        bus.dp_ready_i  = 1'b0;
    endtask

    task automatic core_write(input logic [8:0] a, input logic [31:0] d);
        bus.mem_cenb_i = 1'b0;
        bus.mem_wenb_i = 1'b0;
        bus.mem_addr_i = a;
        bus.mem_data_i = d;
        tick();
        bus.mem_cenb_i = 1'b1;
        bus.mem_wenb_i = 1'b1;
        ref_mem[a] = d;
        ref_ok[a]  = 1'b1;
    endtask

    task automatic core_read(input logic [8:0] a);
        bus.mem_cenb_i = 1'b0;
        bus.mem_wenb_i = 1'b1;
        bus.mem_addr_i = a;
        tick();
        chk("core_rd", bus.mem_data_o, ref_mem[a]);
        bus.mem_cenb_i = 1'b1;
    endtask

    task automatic start_cmd(input logic dir, input logic [8:0] base, input logic [9:0] len);
        bus.start_i     = 1'b1;
        bus.dir_i       = dir;
        bus.base_addr_i = base;
        bus.len_i       = len;
        tick();
        bus.start_i     = 1'b0;
    endtask

    // LOAD len words from ld_bytes; optional idle gaps and core-port traffic
    task automatic do_load(input logic [8:0] base, input int len, input bit gaps, input bit interfere);
        logic [31:0] rd_before;
        int          ng;
        int          a;
        start_cmd(1'b0, base, 10'(len));
        rd_before = bus.mem_data_o;
        chk("load_busy", {63'd0, bus.busy_o}, 64'd1);
        for (int k = 0; k < len * 4; k++) begin
            ng = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < ng; g++) begin
                bus.ld_valid_i = 1'b0;
                if (interfere) begin
                    bus.mem_cenb_i = 1'b0;
                    bus.mem_wenb_i = 1'($urandom_range(0, 1));
                    bus.mem_addr_i = 9'h100;
                    bus.mem_data_i = 32'hDEADBEEF;
                end
                tick();
                chk("load_gap_done", {63'd0, bus.done_o}, 64'd0);
            end
            bus.ld_valid_i = 1'b1;
            bus.ld_byte_i  = ld_bytes[k];
            if (interfere) begin
                bus.mem_cenb_i = 1'b0;
                bus.mem_wenb_i = 1'($urandom_range(0, 1));
                bus.mem_addr_i = 9'h100;
                bus.mem_data_i = 32'hDEADBEEF;
            end
            chk("ld_ready", {63'd0, bus.ld_ready_o}, 64'd1);
            tick();
            if (interfere) chk("load_core_hold", bus.mem_data_o, rd_before);
        end
        bus.ld_valid_i = 1'b0;
        bus.mem_cenb_i = 1'b1;
        bus.mem_wenb_i = 1'b1;
        chk("load_done", {63'd0, bus.done_o}, 64'd1);
        chk("load_busy_end", {63'd0, bus.busy_o}, 64'd0);
        chk("load_ready_end", {63'd0, bus.ld_ready_o}, 64'd0);
        for (int w = 0; w < len; w++) begin
            a = (int'(base) + w) % DEPTH;
            ref_mem[a] = {ld_bytes[4*w+3], ld_bytes[4*w+2], ld_bytes[4*w+1], ld_bytes[4*w]};
            ref_ok[a]  = 1'b1;
        end
        tick();
        chk("load_done_pulse", {63'd0, bus.done_o}, 64'd0);
    endtask

    // mode 0: ready toggles 1/0, mode 1: random ready, mode 2: ready held high
    task automatic do_dump(input logic [8:0] base, input int len, input int mode, input bit inject);
        logic [7:0]  exp_q [$];
        logic [31:0] word;
        int          idx;
        int          cyc;
        int          total;
        bit          stall;
        bit          rdy;
        logic [7:0]  prev_b;
        idx = 0; cyc = 0; total = len * 4; stall = 1'b0; prev_b = '0;
        for (int w = 0; w < len; w++) begin
            word = ref_mem[(int'(base) + w) % DEPTH];
            for (int l = 0; l < LANES; l++) exp_q.push_back(word[8*l +: 8]);
        end
        start_cmd(1'b1, base, 10'(len));
        chk("dump_busy", {63'd0, bus.busy_o}, 64'd1);
        while (idx < total && cyc < 10 * total + 20) begin
            case (mode)
                0:       rdy = (cyc % 2 == 0);
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            bus.dp_ready_i = rdy;
            if (inject) begin
                bus.start_i     = (cyc == 2);
                bus.dir_i       = 1'b0;
                bus.len_i       = 10'd1;
                bus.base_addr_i = 9'h000;
            end
            if (stall) begin
                chk("dump_valid_hold", {63'd0, bus.dp_valid_o}, 64'd1);
                chk("dump_byte_hold", {56'd0, bus.dp_byte_o}, {56'd0, prev_b});
            end
            stall  = bus.dp_valid_o && !rdy;
            prev_b = bus.dp_byte_o;
            if (bus.dp_valid_o && rdy) begin
                chk("dump_byte", {56'd0, bus.dp_byte_o}, {56'd0, exp_q[idx]});
                idx++;
            end
            tick();
            cyc++;
        end
        bus.dp_ready_i = 1'b0;
        bus.start_i    = 1'b0;
        chk("dump_complete", 64'(idx), 64'(total));
        chk("dump_done", {63'd0, bus.done_o}, 64'd1);
        chk("dump_busy_end", {63'd0, bus.busy_o}, 64'd0);
        chk("dump_valid_end", {63'd0, bus.dp_valid_o}, 64'd0);
        if (mode == 2) chk("dump_cycles", 64'(cyc), 64'(5 * len));
        tick();
        chk("dump_done_pulse", {63'd0, bus.done_o}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] ra;
        int         rl;
        int         op;

        // Core-port table: expected mem_data_o after each edge
        tbl[0]  = '{1'b0, 1'b0, 9'h005, 32'hA5A50001, 32'h00000000};
        tbl[1]  = '{1'b0, 1'b0, 9'h006, 32'h5A5A0002, 32'h00000000};
        tbl[2]  = '{1'b0, 1'b1, 9'h005, 32'h00000000, 32'hA5A50001};
        tbl[3]  = '{1'b1, 1'b1, 9'h006, 32'h00000000, 32'hA5A50001};
        tbl[4]  = '{1'b0, 1'b1, 9'h006, 32'h00000000, 32'h5A5A0002};
        tbl[5]  = '{1'b0, 1'b0, 9'h005, 32'hFFFF0000, 32'h5A5A0002};
        tbl[6]  = '{1'b0, 1'b1, 9'h005, 32'h00000000, 32'hFFFF0000};
        tbl[7]  = '{1'b1, 1'b0, 9'h006, 32'h00000000, 32'hFFFF0000};
        tbl[8]  = '{1'b0, 1'b1, 9'h006, 32'h00000000, 32'h5A5A0002};
        tbl[9]  = '{1'b0, 1'b0, 9'h1FF, 32'h12345678, 32'h5A5A0002};
        tbl[10] = '{1'b0, 1'b1, 9'h1FF, 32'h00000000, 32'h12345678};

        idle_inputs();

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_mem_data", bus.mem_data_o, 64'd0);
        chk("rst_dp_byte", {56'd0, bus.dp_byte_o}, 64'd0);
        chk("rst_ld_ready", {63'd0, bus.ld_ready_o}, 64'd0);
        chk("rst_dp_valid", {63'd0, bus.dp_valid_o}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("rst_done", {63'd0, bus.done_o}, 64'd0);
        rst = 1'b0;

        // Table-driven core accesses
        for (int i = 0; i < 11; i++) begin
            bus.mem_cenb_i = tbl[i].cenb;
            bus.mem_wenb_i = tbl[i].wenb;
            bus.mem_addr_i = tbl[i].addr;
            bus.mem_data_i = tbl[i].wdata;
            tick();
            chk("tbl_core", bus.mem_data_o, tbl[i].exp_rd);
            if (!tbl[i].cenb && !tbl[i].wenb) begin
                ref_mem[tbl[i].addr] = tbl[i].wdata;
                ref_ok[tbl[i].addr]  = 1'b1;
            end
        end
        bus.mem_cenb_i = 1'b1;
        bus.mem_wenb_i = 1'b1;

        // LOAD across the address wrap, bytes 0x01..0x0C back-to-back
        ld_bytes.delete();
        for (int k = 1; k <= 12; k++) ld_bytes.push_back(8'(k));
        do_load(9'h1FE, 3, 1'b0, 1'b0);

        // Core read latency and hold
        bus.mem_cenb_i = 1'b0;
        bus.mem_wenb_i = 1'b1;
        bus.mem_addr_i = 9'h1FF;
        tick();
        chk("t3_rd_1ff", bus.mem_data_o, 64'h08070605);
        bus.mem_cenb_i = 1'b1;
        bus.mem_addr_i = 9'h000;
        tick();
        chk("t3_hold", bus.mem_data_o, 64'h08070605);
        bus.mem_cenb_i = 1'b0;
        bus.mem_addr_i = 9'h1FE;
        tick();
        chk("t3_rd_1fe", bus.mem_data_o, 64'h04030201);
        bus.mem_addr_i = 9'h000;
        tick();
        chk("t3_rd_000", bus.mem_data_o, 64'h0C0B0A09);
        bus.mem_cenb_i = 1'b1;

        // DUMP across the wrap with toggling ready
        do_dump(9'h1FE, 3, 0, 1'b0);

        // Core traffic during LOAD is ignored; start_i during DUMP is ignored
        core_write(9'h100, 32'hCAFEF00D);
        core_read(9'h100);
        ld_bytes.delete();
        for (int k = 0; k < 8; k++) ld_bytes.push_back(8'($urandom));
        do_load(9'h010, 2, 1'b1, 1'b1);
        core_read(9'h100);
        chk("t5_victim", bus.mem_data_o, 64'hCAFEF00D);
        do_dump(9'h010, 2, 2, 1'b1);

        // Zero-length commands
        core_write(9'h020, 32'h13579BDF);
        start_cmd(1'b0, 9'h020, 10'd0);
        chk("len0_ld_done", {63'd0, bus.done_o}, 64'd1);
        chk("len0_ld_busy", {63'd0, bus.busy_o}, 64'd0);
        tick();
        chk("len0_ld_pulse", {63'd0, bus.done_o}, 64'd0);
        start_cmd(1'b1, 9'h020, 10'd0);
        chk("len0_dp_done", {63'd0, bus.done_o}, 64'd1);
        chk("len0_dp_valid", {63'd0, bus.dp_valid_o}, 64'd0);
        tick();
        core_read(9'h020);

        // Reset after 6 bytes of a 2-word LOAD
        core_write(9'h050, 32'h11111111);
        core_write(9'h051, 32'h22222222);
        start_cmd(1'b0, 9'h050, 10'd2);
        for (int k = 0; k < 6; k++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_byte_i  = 8'(8'hA0 + k);
            tick();
        end
        bus.ld_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("abort_ready", {63'd0, bus.ld_ready_o}, 64'd0);
        chk("abort_done", {63'd0, bus.done_o}, 64'd0);
        ref_mem[9'h050] = 32'hA3A2A1A0;
        core_read(9'h050);
        core_read(9'h051);

        // Randomized mix against the reference array
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 2) == 0) ? 9'(510 + $urandom_range(0, 1)) : 9'($urandom_range(0, DEPTH - 1));
            case (op)
                0: core_write(ra, $urandom);
                1: begin
                    if (!ref_ok[ra]) core_write(ra, $urandom);
                    core_read(ra);
                end
                2: begin
                    rl = int'($urandom_range(1, 4));
                    ld_bytes.delete();
                    for (int k = 0; k < rl * 4; k++) ld_bytes.push_back(8'($urandom));
                    do_load(ra, rl, 1'b1, 1'($urandom_range(0, 1)));
                end
                default: begin
                    rl = int'($urandom_range(1, 4));
                    for (int w = 0; w < rl; w++) begin
                        if (!ref_ok[(int'(ra) + w) % DEPTH]) core_write(9'((int'(ra) + w) % DEPTH), $urandom);
                    end
                    do_dump(ra, rl, int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
